alu_rs: RTL
===========

Name: alu_rs

Overview:
- Reservation station that feeds the ALU functional unit. It is the transmitter side of the FU input interface: input_transmit, operand, depvals, wbs, flags and robid.
- Buffers dispatched ALU ops until both source operands are available.
- Snoops the CDB to wake up waiting operands.
- Issues the oldest ready entry to the FU whenever the FU is not busy.

Parameters:
- DEPTH, 4, number of entries (2..8).
- TAGW, 4, ROB tag width; matches robid and cdb_id.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- flush  input  1  synchronous clear of all entries (mispredict)
- dispatch_valid  input  1  dispatch request this cycle
- dispatch_ready  output  1  entry free; combinational, equals count != DEPTH
- dispatch_operand  input  8  op/immediate byte
- dispatch_dep_rdy  input  2  per-source value already valid
- dispatch_dep_tag  input  2x TAGW  producer ROB tag per source
- dispatch_dep_val  input  2x8  source value when the ready bit is set
- dispatch_wbs  input  8  writeback selector, passed through
- dispatch_flags  input  8  op flags, passed through
- dispatch_robid  input  TAGW  destination ROB tag
- cdb_valid  input  1  CDB broadcast valid
- cdb_id  input  TAGW  CDB tag
- cdb_val  input  8  CDB value
- fu_busy  input  1  FU stall (FU busy output)
- input_transmit  output  1  one-cycle issue strobe to the FU
- operand  output  8  issued operand
- depvals  output  2x8  issued source values
- wbs  output  8  issued wbs
- flags  output  8  issued flags
- robid  output  TAGW  issued ROB tag
- count  output  clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (rst low, async): all entries invalid, count=0, input_transmit=0.
  - operand, depvals, wbs, flags and robid reset to 0.
- Storage is a collapsing queue. Entry 0 is the oldest. Each entry holds: valid, operand, wbs, flags, robid, and per source rdy/tag/val.
- Dispatch:
  - Accepted on the clk edge when dispatch_valid && dispatch_ready.
  - Written at position count, or count-1 if an issue happens on the same edge.
  - Full blocks dispatch even when an issue happens the same cycle, because dispatch_ready is not made issue-aware.
  - dispatch_valid while not ready is ignored; no state changes.
- Wakeup:
  - Each edge with cdb_valid set, every valid entry source with rdy=0 and tag==cdb_id captures cdb_val and sets rdy=1.
  - A dispatching source with rdy=0 and tag==cdb_id in the same cycle is captured as ready with cdb_val. No lost wakeup.
- Issue selection: the lowest-index valid entry with both rdy bits set.
- Issue:
  - If fu_busy=0 and a candidate exists, the next edge registers its fields onto the outputs and sets input_transmit=1 for exactly one cycle.
  - The entry is removed and younger entries shift down by one with their wakeups applied.
  - Otherwise input_transmit=0; the data outputs hold their last values.
- fu_busy is sampled combinationally in the issue cycle. While it is high, no issue occurs and entries keep accumulating wakeups.
- Latency (minimum):
  - Dispatch with both sources ready: input_transmit goes high 1 cycle after the dispatch edge.
  - CDB wakeup: issue on the edge after the capture edge.
- Count:
  - +1 on dispatch, -1 on issue, unchanged when both happen.
  - Never exceeds DEPTH and never underflows.
- Flush: on the next edge all entries are invalidated, count=0, input_transmit=0.
  - Flush has priority over dispatch, issue and wakeup in the same cycle.
- Immediate ops: the dispatcher sets dispatch_dep_rdy[1]=1. The station does not decode flags.

Optional Feature:
- Macro: ALU_RS_CDB_BYPASS_EN.
- Defined:
  - An entry whose only missing source(s) match this cycle's CDB broadcast counts as an issue candidate in the same cycle.
  - The issued depvals take cdb_val for each matching source.
  - This cuts wakeup-to-issue latency to 1 edge.
  - Selection still picks the oldest candidate.
- Undefined: wakeup always takes one extra edge, as described above.

Test Plan:
- Reset, then dispatch operand=0x00, flags=0, dep_rdy=11, vals 0x05/0x03, robid=2 -> next cycle input_transmit=1 for one cycle, depvals={0x05,0x03}, robid=2; count returns to 0.
- Dispatch with dep0 waiting on tag 7; 3 idle cycles -> no issue. cdb_valid, id=7, val=0x42 -> issue 1 edge later with depvals[0]=0x42; with ALU_RS_CDB_BYPASS_EN, issue on the capture edge.
- Fill 4 ready entries while fu_busy=1 -> dispatch_ready=0, count=4, no strobe; a 5th dispatch is ignored. Drop fu_busy -> 4 consecutive strobes in dispatch order (robid 0,1,2,3).
- Entry A (older) waits on tag 3 and entry B (younger) is ready -> B issues first. A issues after cdb id=3 arrives; order confirmed by robid.
- Dispatch whose dep tag 5 matches cdb_valid id=5 in the same cycle -> entry captured ready and issued next cycle with the CDB value.
- 3 entries held, then flush asserted together with dispatch_valid and fu_busy=0 -> count=0, no strobe, the new dispatch is dropped. rst pulsed low mid-issue -> outputs clear asynchronously.

Source files
------------

// File: rtl/alu_rs.sv
// ALU reservation station: collapsing queue, CDB wakeup, oldest-ready issue.
// Optional same-cycle CDB bypass to issue is enabled by defining ALU_RS_CDB_BYPASS_EN.
module alu_rs #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAGW  = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 dispatch_valid,
    output logic                 dispatch_ready,
    input  logic [7:0]           dispatch_operand,
    input  logic [1:0]           dispatch_dep_rdy,
    input  logic [1:0][TAGW-1:0] dispatch_dep_tag,
    input  logic [1:0][7:0]      dispatch_dep_val,
    input  logic [7:0]           dispatch_wbs,
    input  logic [7:0]           dispatch_flags,
    input  logic [TAGW-1:0]      dispatch_robid,
    input  logic                 cdb_valid,
    input  logic [TAGW-1:0]      cdb_id,
    input  logic [7:0]           cdb_val,
    input  logic                 fu_busy,
    output logic                 input_transmit,
    output logic [7:0]           operand,
    output logic [1:0][7:0]      depvals,
    output logic [7:0]           wbs,
    output logic [7:0]           flags,
    output logic [TAGW-1:0]      robid,
    output logic [CW-1:0]        count
);

    typedef struct packed {
        logic                 v;
        logic [7:0]           op;
        logic [7:0]           wbs;
        logic [7:0]           fl;
        logic [TAGW-1:0]      rob;
        logic [1:0]           rdy;
        logic [1:0][TAGW-1:0] tag;
        logic [1:0][7:0]      val;
    } ent_t;

    ent_t            ent_q [DEPTH];
    ent_t            ent_d [DEPTH];
    ent_t            woke  [DEPTH+1];
    ent_t            disp_ent;
    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] shift;
    logic            any_cand;
    logic            issue;
    logic            disp_acc;
    logic [CW-1:0]   wp;
    logic [CW-1:0]   count_q, count_d;

    logic [7:0]      iss_op, iss_wbs, iss_fl;
    logic [TAGW-1:0] iss_rob;
    logic [1:0][7:0] iss_val;

    logic            tx_q;
    logic [7:0]      op_q, wbs_q, fl_q;
    logic [TAGW-1:0] rob_q;
    logic [1:0][7:0] dv_q;

    // Entries with this cycle's CDB broadcast applied; the extra slot feeds the collapse of the top entry.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            for (int unsigned s = 0; s < 2; s++) begin
                if (cdb_valid && ent_q[i].v && !ent_q[i].rdy[s] && ent_q[i].tag[s] == cdb_id) begin
                    woke[i].rdy[s] = 1'b1;
                    woke[i].val[s] = cdb_val;
                end
            end
        end
        woke[DEPTH] = '0;
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef ALU_RS_CDB_BYPASS_EN
            cand[i] = woke[i].v && (&woke[i].rdy);
`else
            cand[i] = ent_q[i].v && (&ent_q[i].rdy);
`endif
        end
    end

    // shift[i] marks entries at or above the selected slot; those take their younger neighbour.
    always_comb begin
        any_cand = 1'b0;
        shift    = '0;
        iss_op   = '0;
        iss_wbs  = '0;
        iss_fl   = '0;
        iss_rob  = '0;
        iss_val  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!any_cand && cand[i]) begin
                any_cand = 1'b1;
                iss_op   = woke[i].op;
                iss_wbs  = woke[i].wbs;
                iss_fl   = woke[i].fl;
                iss_rob  = woke[i].rob;
                iss_val  = woke[i].val;
            end
            shift[i] = any_cand;
        end
        issue = any_cand && !fu_busy;
    end

    assign dispatch_ready = (count_q != CW'(DEPTH));
    assign disp_acc       = dispatch_valid && dispatch_ready;
    assign wp             = issue ? (count_q - CW'(1)) : count_q;

    always_comb begin
        disp_ent     = '0;
        disp_ent.v   = 1'b1;
        disp_ent.op  = dispatch_operand;
        disp_ent.wbs = dispatch_wbs;
        disp_ent.fl  = dispatch_flags;
        disp_ent.rob = dispatch_robid;
        disp_ent.tag = dispatch_dep_tag;
        for (int unsigned s = 0; s < 2; s++) begin
            if (dispatch_dep_rdy[s]) begin
                disp_ent.rdy[s] = 1'b1;
                disp_ent.val[s] = dispatch_dep_val[s];
            end else if (cdb_valid && dispatch_dep_tag[s] == cdb_id) begin
                disp_ent.rdy[s] = 1'b1;
                disp_ent.val[s] = cdb_val;
            end else begin
                disp_ent.rdy[s] = 1'b0;
                disp_ent.val[s] = dispatch_dep_val[s];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_d[i] = (issue && shift[i]) ? woke[i+1] : woke[i];
            if (disp_acc && wp == CW'(i)) begin
                ent_d[i] = disp_ent;
            end
        end
        count_d = count_q + CW'(disp_acc) - CW'(issue);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q <= '0;
            tx_q    <= 1'b0;
            op_q    <= '0;
            wbs_q   <= '0;
            fl_q    <= '0;
            rob_q   <= '0;
            dv_q    <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q <= '0;
            tx_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q <= count_d;
            tx_q    <= issue;
            if (issue) begin
                op_q  <= iss_op;
                wbs_q <= iss_wbs;
                fl_q  <= iss_fl;
                rob_q <= iss_rob;
                dv_q  <= iss_val;
            end
        end
    end

    assign input_transmit = tx_q;
    assign operand        = op_q;
    assign depvals        = dv_q;
    assign wbs            = wbs_q;
    assign flags          = fl_q;
    assign robid          = rob_q;
    assign count          = count_q;

endmodule
